// File: rtl/spi_ram_arbiter.sv
// rtl/spi_ram_arbiter.sv - SPI command decoder sharing one RAM port with a host via round-robin arbitration
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [DATA_SIZE+1:0] rx_data,
  output logic                 tx_valid,
  output logic [DATA_SIZE-1:0] tx_data,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [DATA_SIZE-1:0] host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [DATA_SIZE-1:0] host_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic                 ovr_err
);

  typedef enum logic {GNT_SPI = 1'b0, GNT_HOST = 1'b1} grant_t;

  grant_t                 last_grant;
  logic [ADDR_SIZE-1:0]   wr_addr;
  logic [ADDR_SIZE-1:0]   rd_addr;
  logic                   pend_v;
  logic                   pend_we;
  logic [ADDR_SIZE-1:0]   pend_addr;
  logic [DATA_SIZE-1:0]   pend_wdata;
  logic                   rd1_v;
  logic                   rd1_host;
  logic                   spi_win;
  logic                   host_win;
  logic [1:0]             cmd;
  logic [ADDR_SIZE-1:0]   payload_addr;
  logic [DATA_SIZE-1:0]   payload_data;

  assign cmd          = rx_data[DATA_SIZE+1:DATA_SIZE];
  assign payload_addr = rx_data[ADDR_SIZE-1:0];
  assign payload_data = rx_data[DATA_SIZE-1:0];

  // Under contention the requester that did not win last time goes next.
  assign spi_win  = !rst && pend_v && (!host_req || last_grant == GNT_HOST);
  assign host_win = !rst && host_req && !spi_win;
  assign host_gnt = host_win;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (spi_win) begin
      mem_en    = 1'b1;
      mem_we    = pend_we;
      mem_addr  = pend_addr;
      mem_wdata = pend_wdata;
    end else if (host_win) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= GNT_HOST;
      wr_addr     <= '0;
      rd_addr     <= '0;
      pend_v      <= 1'b0;
      pend_we     <= 1'b0;
      pend_addr   <= '0;
      pend_wdata  <= '0;
      rd1_v       <= 1'b0;
      rd1_host    <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      ovr_err     <= 1'b0;
    end else begin
      ovr_err     <= 1'b0;
      tx_valid    <= 1'b0;
      host_rvalid <= 1'b0;

      if (spi_win) pend_v <= 1'b0;

      // Memory commands use the address registers as they were before this cycle.
      if (rx_valid) begin
        case (cmd)
          2'b00: wr_addr <= payload_addr;
          2'b10: rd_addr <= payload_addr;
          default: begin
            if (!pend_v || spi_win) begin
              pend_v     <= 1'b1;
              pend_we    <= !cmd[1];
              pend_addr  <= cmd[1] ? rd_addr : wr_addr;
              pend_wdata <= cmd[1] ? '0 : payload_data;
            end else begin
              ovr_err <= 1'b1;
            end
          end
        endcase
      end

      if (spi_win)       last_grant <= GNT_SPI;
      else if (host_win) last_grant <= GNT_HOST;

      rd1_v    <= mem_en && !mem_we;
      rd1_host <= host_win;

      if (rd1_v) begin
        if (rd1_host) begin
          host_rvalid <= 1'b1;
          host_rdata  <= mem_rdata;
        end else begin
          tx_valid <= 1'b1;
          tx_data  <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb/tb_spi_ram_arbiter.sv - scoreboard bench for spi_ram_arbiter with a behavioural RAM
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [9:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic       host_rvalid;
  logic [7:0] host_rdata;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       ovr_err;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t tx_q[$];
  exp_t host_q[$];
  exp_t te;
  exp_t he;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic [7:0] ram [256];

  spi_ram_arbiter #(.ADDR_SIZE(8), .DATA_SIZE(8)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM: read data appears the cycle after the read is issued.
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic rx(input logic [9:0] w);
    rx_valid = 1'b1;
    rx_data  = w;
  endtask

  task automatic rx_off();
    rx_valid = 1'b0;
    rx_data  = 10'h000;
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_q.push_back('{d: d, c: cyc + 2});
  endtask

  task automatic push_host(input logic [7:0] d);
    host_q.push_back('{d: d, c: cyc + 2});
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_tx_valid"}, int'(tx_valid), 0);
    chk({tag, "_tx_data"}, int'(tx_data), 0);
    chk({tag, "_host_gnt"}, int'(host_gnt), 0);
    chk({tag, "_host_rvalid"}, int'(host_rvalid), 0);
    chk({tag, "_host_rdata"}, int'(host_rdata), 0);
    chk({tag, "_mem_en"}, int'(mem_en), 0);
    chk({tag, "_mem_addr"}, int'(mem_addr), 0);
    chk({tag, "_ovr_err"}, int'(ovr_err), 0);
  endtask

  // Monitor: every response strobe must match the head of its queue, in data and cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_valid) begin
        if (tx_q.size() == 0) begin
          chk("tx_unexpected", int'(tx_data), -1);
        end else begin
          te = tx_q.pop_front();
          chk("tx_data", int'(tx_data), int'(te.d));
          chk("tx_cycle", cyc, te.c);
        end
      end
      if (host_rvalid) begin
        if (host_q.size() == 0) begin
          chk("host_unexpected", int'(host_rdata), -1);
        end else begin
          he = host_q.pop_front();
          chk("host_rdata", int'(host_rdata), int'(he.d));
          chk("host_cycle", cyc, he.c);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    rx_off();
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
    step(); step();
    at_neg();
    chk_idle_outputs("reset");
    step();
    rst = 1'b0;

    // SPI write: wr_addr=0x2A, then write 0x5C
    rx(10'h02A); at_neg(); chk("w_addr_noacc", int'(mem_en), 0); step();
    rx(10'h15C); at_neg(); chk("w_cmd_noacc", int'(mem_en), 0); step();
    rx_off(); at_neg();
    chk("w_en", int'(mem_en), 1);
    chk("w_we", int'(mem_we), 1);
    chk("w_addr", int'(mem_addr), 'h2A);
    chk("w_wdata", int'(mem_wdata), 'h5C);
    step(); at_neg(); chk("w_done_idle", int'(mem_en), 0);

    // SPI read of 0x2A, expected on tx at N+3
    step(); rx(10'h22A);
    step(); rx(10'h300); at_neg(); chk("r_n_noacc", int'(mem_en), 0);
    step(); rx_off(); at_neg();
    chk("r_en", int'(mem_en), 1);
    chk("r_we", int'(mem_we), 0);
    chk("r_addr", int'(mem_addr), 'h2A);
    push_tx(8'h5C);
    step(); step(); step();

    // Host writes 0x00=0xFF, 0x10=0x77, then reads 0x00
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h00; host_wdata = 8'hFF;
    at_neg();
    chk("hw_gnt", int'(host_gnt), 1);
    chk("hw_we", int'(mem_we), 1);
    chk("hw_wdata", int'(mem_wdata), 'hFF);
    step(); host_addr = 8'h10; host_wdata = 8'h77;
    at_neg(); chk("hw2_gnt", int'(host_gnt), 1);
    step(); host_we = 1'b0; host_addr = 8'h00;
    at_neg();
    chk("hr_gnt", int'(host_gnt), 1);
    chk("hr_we", int'(mem_we), 0);
    push_host(8'hFF);
    step(); host_req = 1'b0;
    step(); step();

    // Contention: SPI first (last grant was host), then strict alternation
    rx(10'h300); at_neg(); chk("alt_idle", int'(mem_en), 0);
    step(); rx_off(); host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    at_neg();
    chk("alt_spi_first_gnt", int'(host_gnt), 0);
    chk("alt_spi_first_addr", int'(mem_addr), 'h2A);
    push_tx(8'h5C);
    step();
    for (int i = 0; i < 2; i++) begin
      rx(10'h300); at_neg();
      chk("alt_host_gnt", int'(host_gnt), 1);
      chk("alt_host_addr", int'(mem_addr), 'h10);
      push_host(8'h77);
      step(); rx_off(); at_neg();
      chk("alt_spi_gnt", int'(host_gnt), 0);
      chk("alt_spi_addr", int'(mem_addr), 'h2A);
      push_tx(8'h5C);
      step();
    end
    at_neg(); chk("alt_last_host_gnt", int'(host_gnt), 1);
    push_host(8'h77);
    step(); host_req = 1'b0;
    step(); step();

    // Overrun: second read arrives while host holds the port
    rx(10'h15C); at_neg(); chk("ov_idle", int'(mem_en), 0);
    step(); rx(10'h300); host_req = 1'b1;
    at_neg();
    chk("ov_spi_write_gnt", int'(host_gnt), 0);
    chk("ov_spi_write_we", int'(mem_we), 1);
    step(); rx(10'h300);
    at_neg();
    chk("ov_host_gnt", int'(host_gnt), 1);
    chk("ov_err_before", int'(ovr_err), 0);
    push_host(8'h77);
    step(); rx_off(); host_req = 1'b0;
    at_neg();
    chk("ov_err_pulse", int'(ovr_err), 1);
    chk("ov_read_issue", int'(mem_en), 1);
    chk("ov_read_we", int'(mem_we), 0);
    push_tx(8'h5C);
    step(); at_neg(); chk("ov_err_clear", int'(ovr_err), 0);
    step(); step(); step();

    // Reset one cycle after an SPI read issues: read is discarded
    rx(10'h300);
    step(); rx_off(); at_neg(); chk("rr_issue", int'(mem_en), 1);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    at_neg();
    chk_idle_outputs("post_rst");
    // rd_addr reset to 0x00, which holds 0xFF
    rx(10'h300);
    step(); rx_off(); host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    at_neg();
    chk("rst_first_gnt_host", int'(host_gnt), 0);
    chk("rst_first_addr", int'(mem_addr), 'h00);
    push_tx(8'hFF);
    step(); at_neg(); chk("rst_second_gnt_host", int'(host_gnt), 1);
    push_host(8'h77);
    step(); host_req = 1'b0;
    repeat (5) step();

    chk("tx_queue_drained", tx_q.size(), 0);
    chk("host_queue_drained", host_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
